// File: rtl/offset_update_scheduler_if.sv
// Offset-update scheduler bus: software write port, read-side metadata and the
// offset-memory write port with buffer status.
interface offset_update_scheduler_if #(
  parameter int unsigned WORD_WIDTH = 10,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned INCR_WIDTH = 4
);
  logic                  sw_wren;
  logic [ADDR_WIDTH-1:0] sw_addr;
  logic [WORD_WIDTH-1:0] sw_data;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  postinc_en;
  logic [INCR_WIDTH-1:0] increment;
  logic [WORD_WIDTH-1:0] offset;
  logic                  ram_wren;
  logic [ADDR_WIDTH-1:0] ram_write_addr;
  logic [WORD_WIDTH-1:0] ram_write_data;
  logic                  pending;
  logic                  dropped;

  modport master (
    output sw_wren, sw_addr, sw_data, read_addr, postinc_en, increment, offset,
    input  ram_wren, ram_write_addr, ram_write_data, pending, dropped
  );

  modport slave (
    input  sw_wren, sw_addr, sw_data, read_addr, postinc_en, increment, offset,
    output ram_wren, ram_write_addr, ram_write_data, pending, dropped
  );
endinterface

// File: rtl/offset_update_scheduler.sv
// Schedules post-increment write-backs to an offset memory, arbitrating against
// software writes with a single-entry deferred-update buffer.
module offset_update_scheduler #(
  parameter int unsigned WORD_WIDTH   = 10,
  parameter int unsigned ADDR_WIDTH   = 3,
  parameter int unsigned INCR_WIDTH   = 4,
  parameter int unsigned READ_LATENCY = 2
) (
  input logic                     clock,
  input logic                     reset,
  offset_update_scheduler_if.slave bus
);

  localparam int unsigned Last = READ_LATENCY - 1;

  logic                  pipe_en_q   [READ_LATENCY];
  logic [ADDR_WIDTH-1:0] pipe_addr_q [READ_LATENCY];
  logic [INCR_WIDTH-1:0] pipe_inc_q  [READ_LATENCY];

  logic                  pend_valid_q, pend_valid_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [WORD_WIDTH-1:0] pend_data_q, pend_data_d;

  logic                  ram_wren_q, ram_wren_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [WORD_WIDTH-1:0] ram_data_q, ram_data_d;
  logic                  dropped_q, dropped_d;

  logic                  take_fresh;
  logic [ADDR_WIDTH-1:0] fresh_addr;
  logic [WORD_WIDTH-1:0] fresh_data;

  assign fresh_addr = pipe_addr_q[Last];
  assign fresh_data = bus.offset + WORD_WIDTH'($signed(pipe_inc_q[Last]));

  always_comb begin
    ram_wren_d   = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    dropped_d    = 1'b0;
    take_fresh   = pipe_en_q[Last];

    if (bus.sw_wren) begin
      ram_wren_d = 1'b1;
      ram_addr_d = bus.sw_addr;
      ram_data_d = bus.sw_data;
      // Software writes supersede any hardware update to the same address.
      if (pend_valid_q && (pend_addr_q == bus.sw_addr)) pend_valid_d = 1'b0;
      if (take_fresh && (fresh_addr == bus.sw_addr)) take_fresh = 1'b0;
      if (take_fresh) begin
        if (!pend_valid_d) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = fresh_addr;
          pend_data_d  = fresh_data;
        end else begin
          dropped_d = 1'b1;
        end
      end
    end else if (pend_valid_q) begin
      ram_wren_d   = 1'b1;
      ram_addr_d   = pend_addr_q;
      ram_data_d   = pend_data_q;
      pend_valid_d = 1'b0;
      if (take_fresh) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = fresh_addr;
        pend_data_d  = fresh_data;
      end
    end else if (take_fresh) begin
      ram_wren_d = 1'b1;
      ram_addr_d = fresh_addr;
      ram_data_d = fresh_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_en_q[i]   <= 1'b0;
        pipe_addr_q[i] <= '0;
        pipe_inc_q[i]  <= '0;
      end
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      ram_wren_q   <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      dropped_q    <= 1'b0;
    end else begin
      pipe_en_q[0]   <= bus.postinc_en;
      pipe_addr_q[0] <= bus.read_addr;
      pipe_inc_q[0]  <= bus.increment;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_en_q[i]   <= pipe_en_q[i-1];
        pipe_addr_q[i] <= pipe_addr_q[i-1];
        pipe_inc_q[i]  <= pipe_inc_q[i-1];
      end
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      ram_wren_q   <= ram_wren_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      dropped_q    <= dropped_d;
    end
  end

  assign bus.ram_wren       = ram_wren_q;
  assign bus.ram_write_addr = ram_addr_q;
  assign bus.ram_write_data = ram_data_q;
  assign bus.pending        = pend_valid_q;
  assign bus.dropped        = dropped_q;

endmodule

// File: doc/offset_update_scheduler.md
OFFSET_UPDATE_SCHEDULER -- requirements
Module: Offset_Update_Scheduler

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 10: width of each offset word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3: width of an offset-memory address (one entry per thread/operand slot).
REQ-003 SHALL have parameter INCR_WIDTH, default 4: width of the signed two's-complement post-increment.
REQ-004 SHALL have parameter READ_LATENCY, default 2: cycles from read_addr to offset valid; legal range 1..4.
REQ-005 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port sw_wren, input, 1: software (memory-mapped) write request to offset memory.
REQ-008 SHALL have port sw_addr, input, ADDR_WIDTH: software write address.
REQ-009 SHALL have port sw_data, input, WORD_WIDTH: software write data.
REQ-010 SHALL have port read_addr, input, ADDR_WIDTH: address presented to offset memory this cycle.
REQ-011 SHALL have port postinc_en, input, 1: the current read requests post-increment.
REQ-012 SHALL have port increment, input, INCR_WIDTH: signed post-increment for the current read.
REQ-013 SHALL have port offset, input, WORD_WIDTH: offset-memory read data, READ_LATENCY cycles after read_addr.
REQ-014 SHALL have port ram_wren, output, 1: offset-memory write enable.
REQ-015 SHALL have port ram_write_addr, output, ADDR_WIDTH: offset-memory write address.
REQ-016 SHALL have port ram_write_data, output, WORD_WIDTH: offset-memory write data.
REQ-017 SHALL have port pending, output, 1: deferred-update buffer occupied.
REQ-018 SHALL have port dropped, output, 1: one-cycle pulse when a post-increment update is lost.

Function
REQ-019 SHALL carry read_addr, postinc_en and increment through a READ_LATENCY-stage shift pipeline, so each aligns with its offset ("matured" entry).
REQ-020 A matured entry with postinc_en=1 SHALL form candidate data = offset + sign-extended increment, modulo 2^WORD_WIDTH (wrap-around, no saturation).
REQ-021 All outputs SHALL be registered: a decision in cycle T appears on ram_*, pending and dropped in cycle T+1.
REQ-022 Write-port priority per cycle SHALL be: software write > pending buffer > fresh matured update; at most one write per cycle.
REQ-023 A fresh update that cannot issue SHALL enter the 1-entry pending buffer if it is empty or being drained in the same cycle.
REQ-024 A fresh update that cannot issue while the buffer stays full SHALL be discarded, with dropped=1 for one cycle.
REQ-025 A software write to the pending entry's address SHALL clear the buffer without a dropped pulse (software supersedes).
REQ-026 A software write to the same address as a simultaneous fresh update SHALL discard that update without a dropped pulse.
REQ-027 When no write issues, ram_wren SHALL be 0 and ram_write_addr/ram_write_data SHALL hold their previous values.
REQ-028 The block SHALL NOT forward or bypass pending writes to in-flight reads; callers guarantee the same address is not re-read within READ_LATENCY+2 cycles.

Reset
REQ-029 While reset=1 at a clock edge, the block SHALL clear all pipeline valid bits and the pending buffer, and set ram_wren=0, ram_write_addr=0, ram_write_data=0, pending=0, dropped=0.
REQ-030 Reads in flight when reset asserts SHALL produce no write after reset deasserts; sw_wren during reset SHALL be ignored.

Verification (WORD_WIDTH=10, READ_LATENCY=2)
REQ-031 Post-increment: cycle 0 read_addr=3, postinc_en=1, increment=+1; cycle 2 offset=0x005 -> cycle 3 ram_wren=1, addr=3, data=0x006.
REQ-032 Wrap-around: offset=0x3FF with increment=+1 -> data=0x000; offset=0x000 with increment=0xF (-1) -> data=0x3FF.
REQ-033 Collision: sw write addr=5, data=0x100 in the same cycle as a matured update addr=3, data=0x007 -> T+1: write 5/0x100, pending=1; T+2: write 3/0x007, pending=0.
REQ-034 Supersede: sw write addr=5 collides with a matured update to addr=5 -> only the sw write occurs; pending stays 0; dropped stays 0.
REQ-035 Drop: sw_wren held for cycles T..T+2 with matured updates to addrs 1, 2, 3 -> addr 1 is buffered; dropped pulses at T+2 and T+3; addr 1 is written at T+4.
REQ-036 Reset mid-operation: reset for one cycle with pending=1 and two reads in flight -> next cycle ram_wren=0, pending=0; no ram_wren over the following 4 cycles.
